// File: rtl/countdown_sequencer.sv
// countdown_sequencer: turns debounced button codes into one-cycle timer commands and
// tracks IDLE/SET/RUN/PAUSE/RING. Optional macro COUNTDOWN_BG_RUN_EN keeps RUN/RING alive off-page.
module countdown_sequencer #(
    parameter int         RING_CYCLES = 500_000_000,
    parameter int         CNT_W       = 32,
    parameter logic [3:0] CODE_SHORT  = 4'd1,
    parameter logic [3:0] CODE_LONG   = 4'd2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       active,
    input  logic [3:0] btn_start,
    input  logic [3:0] btn_pause,
    input  logic [3:0] btn_clear,
    input  logic [3:0] btn_enter,
    input  logic       preset_zero,
    input  logic       timer_zero,
    output logic       cmd_start,
    output logic       cmd_pause,
    output logic       cmd_reset,
    output logic       cmd_load,
    output logic       set_mode,
    output logic       ring,
    output logic [2:0] seq_state
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SET   = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_PAUSE = 3'd3;
    localparam logic [2:0] ST_RING  = 3'd4;

    localparam int BTN_START = 0;
    localparam int BTN_PAUSE = 1;
    localparam int BTN_CLEAR = 2;
    localparam int BTN_ENTER = 3;

    localparam logic [CNT_W-1:0] RING_LAST = CNT_W'(RING_CYCLES - 1);

    logic [3:0]       btn_code [4];
    logic [3:0]       btn_prev_reg [4];
    logic [3:0]       btn_event;
    logic [2:0]       state_reg, state_next;
    logic [CNT_W-1:0] ring_cnt_reg, ring_cnt_next;
    logic             active_reg;
    logic             start_reg, start_next;
    logic             pause_reg, pause_next;
    logic             reset_reg, reset_next;
    logic             load_reg, load_next;
    logic             act_fall;
    logic             fall_drop;
    logic             proc_en;

    assign btn_code[BTN_START] = btn_start;
    assign btn_code[BTN_PAUSE] = btn_pause;
    assign btn_code[BTN_CLEAR] = btn_clear;
    assign btn_code[BTN_ENTER] = btn_enter;

    // Edge registers track the raw codes even while off-page, so a held button never fires on activation.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_edge
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    btn_prev_reg[gi] <= 4'd0;
                end else begin
                    btn_prev_reg[gi] <= btn_code[gi];
                end
            end
            assign btn_event[gi] = active && (btn_prev_reg[gi] == 4'd0) &&
                                   ((btn_code[gi] == CODE_SHORT) || (btn_code[gi] == CODE_LONG));
        end
    endgenerate

    assign act_fall = active_reg && !active;

`ifdef COUNTDOWN_BG_RUN_EN
    assign fall_drop = act_fall && ((state_reg == ST_SET) || (state_reg == ST_PAUSE));
    assign proc_en   = 1'b1;
`else
    assign fall_drop = act_fall;
    assign proc_en   = active;
`endif

    always_comb begin
        state_next    = state_reg;
        ring_cnt_next = ring_cnt_reg;
        start_next    = 1'b0;
        pause_next    = 1'b0;
        reset_next    = 1'b0;
        load_next     = 1'b0;
        if (fall_drop) begin
            if (state_reg != ST_IDLE) begin
                reset_next = (state_reg != ST_SET);
                state_next = ST_IDLE;
            end
        end else if (proc_en) begin
            case (state_reg)
                ST_IDLE: begin
                    if (btn_event[BTN_START] && !preset_zero) begin
                        start_next = 1'b1;
                        state_next = ST_RUN;
                    end else if (btn_event[BTN_ENTER] && (btn_enter == CODE_LONG)) begin
                        state_next = ST_SET;
                    end
                end
                ST_SET: begin
                    if (btn_event[BTN_CLEAR]) begin
                        state_next = ST_IDLE;
                    end else if (btn_event[BTN_ENTER] && (btn_enter == CODE_SHORT)) begin
                        load_next  = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (timer_zero) begin
                        ring_cnt_next = '0;
                        state_next    = ST_RING;
                    end else if (btn_event[BTN_CLEAR]) begin
                        reset_next = 1'b1;
                        state_next = ST_IDLE;
                    end else if (btn_event[BTN_PAUSE]) begin
                        pause_next = 1'b1;
                        state_next = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (btn_event[BTN_CLEAR]) begin
                        reset_next = 1'b1;
                        state_next = ST_IDLE;
                    end else if (btn_event[BTN_START]) begin
                        start_next = 1'b1;
                        state_next = ST_RUN;
                    end
                end
                ST_RING: begin
                    // Any button acknowledges the alarm; otherwise it times out after RING_CYCLES.
                    if ((|btn_event) || (ring_cnt_reg == RING_LAST)) begin
                        reset_next = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        ring_cnt_next = ring_cnt_reg + CNT_W'(1);
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            ring_cnt_reg <= '0;
            active_reg   <= 1'b0;
            start_reg    <= 1'b0;
            pause_reg    <= 1'b0;
            reset_reg    <= 1'b0;
            load_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ring_cnt_reg <= ring_cnt_next;
            active_reg   <= active;
            start_reg    <= start_next;
            pause_reg    <= pause_next;
            reset_reg    <= reset_next;
            load_reg     <= load_next;
        end
    end

    assign cmd_start = start_reg;
    assign cmd_pause = pause_reg;
    assign cmd_reset = reset_reg;
    assign cmd_load  = load_reg;
    assign set_mode  = (state_reg == ST_SET);
    assign ring      = (state_reg == ST_RING);
    assign seq_state = state_reg;

endmodule

// File: tb/tb_countdown_sequencer.sv
// Bench for countdown_sequencer: directed sequences plus random button traffic, scored against
// a cycle-level reference model through an expectation queue.
module tb_countdown_sequencer;

    localparam int RC = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       active = 1'b0;
    logic [3:0] btn_start = 4'd0;
    logic [3:0] btn_pause = 4'd0;
    logic [3:0] btn_clear = 4'd0;
    logic [3:0] btn_enter = 4'd0;
    logic       preset_zero = 1'b0;
    logic       timer_zero = 1'b0;
    logic       cmd_start, cmd_pause, cmd_reset, cmd_load, set_mode, ring;
    logic [2:0] seq_state;

    always #5 clk = ~clk;

    countdown_sequencer #(.RING_CYCLES(RC), .CNT_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .active(active),
        .btn_start(btn_start), .btn_pause(btn_pause), .btn_clear(btn_clear), .btn_enter(btn_enter),
        .preset_zero(preset_zero), .timer_zero(timer_zero),
        .cmd_start(cmd_start), .cmd_pause(cmd_pause), .cmd_reset(cmd_reset), .cmd_load(cmd_load),
        .set_mode(set_mode), .ring(ring), .seq_state(seq_state)
    );

    typedef struct packed {
        logic       cs, cp, cr, cl, sm, rg;
        logic [2:0] st;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: mode uses the published seq_state numbering; ring time is tracked as cycles left.
    int         m_mode;
    int         m_left;
    logic [3:0] m_prev [4];
    logic       m_pact;

    task automatic model_reset();
        m_mode = 0;
        m_left = 0;
        m_pact = 1'b0;
        for (int i = 0; i < 4; i++) m_prev[i] = 4'd0;
    endtask

    task automatic model_step();
        logic [3:0] cur [4];
        bit ev [4];
        bit any_ev, fall, gone, live, cs, cp, cr, cl;
        int nm;
        cur = '{btn_start, btn_pause, btn_clear, btn_enter};
        any_ev = 0;
        for (int i = 0; i < 4; i++) begin
            ev[i] = active && (m_prev[i] == 0) && (cur[i] == 4'd1 || cur[i] == 4'd2);
            any_ev = any_ev | ev[i];
        end
        fall = m_pact && !active;
`ifdef COUNTDOWN_BG_RUN_EN
        gone = fall && (m_mode == 1 || m_mode == 3);
        live = 1;
`else
        gone = fall;
        live = active;
`endif
        nm = m_mode; cs = 0; cp = 0; cr = 0; cl = 0;
        if (gone) begin
            if (m_mode != 0) begin
                cr = (m_mode != 1);
                nm = 0;
            end
        end else if (live) begin
            if (m_mode == 0) begin
                if (ev[0] && !preset_zero) begin cs = 1; nm = 2; end
                else if (ev[3] && btn_enter == 4'd2) nm = 1;
            end else if (m_mode == 1) begin
                if (ev[2]) nm = 0;
                else if (ev[3] && btn_enter == 4'd1) begin cl = 1; nm = 0; end
            end else if (m_mode == 2) begin
                if (timer_zero) begin nm = 4; m_left = RC; end
                else if (ev[2]) begin cr = 1; nm = 0; end
                else if (ev[1]) begin cp = 1; nm = 3; end
            end else if (m_mode == 3) begin
                if (ev[2]) begin cr = 1; nm = 0; end
                else if (ev[0]) begin cs = 1; nm = 2; end
            end else begin
                if (any_ev || m_left == 1) begin cr = 1; nm = 0; end
                else m_left = m_left - 1;
            end
        end
        m_prev = cur;
        m_pact = active;
        m_mode = nm;
        exp_q.push_back({cs, cp, cr, cl, (nm == 1), (nm == 4), 3'(nm)});
    endtask

    task automatic drive(input logic a, input logic [3:0] s, p, c, e, input logic pz, tz);
        active = a; btn_start = s; btn_pause = p; btn_clear = c; btn_enter = e;
        preset_zero = pz; timer_zero = tz;
        model_step();
    endtask

    task automatic apply(input logic a, input logic [3:0] s, p, c, e, input logic pz, tz);
        @(negedge clk);
        drive(a, s, p, c, e, pz, tz);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, req);
        end
    endtask

    function automatic logic [3:0] rand_code();
        case ($urandom_range(0, 5))
            3: return 4'd1;
            4: return 4'd2;
            5: return 4'd3;
            default: return 4'd0;
        endcase
    endfunction

    // Monitor: one expectation per registered cycle, compared just after the edge.
    initial begin
        exp_t e;
        exp_t got;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got = {cmd_start, cmd_pause, cmd_reset, cmd_load, set_mode, ring, seq_state};
                checks++;
                if (got !== e) begin
                    failures++;
                    $display("FAIL cycle_outputs t=%0t start/pause/reset/load/set/ring/state actual=%b required=%b",
                             $time, got, e);
                end else if (got.cs || got.cp || got.cr || got.cl) begin
                    $display("cmd t=%0t start=%0b pause=%0b reset=%0b load=%0b state=%0d",
                             $time, got.cs, got.cp, got.cr, got.cl, got.st);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog t=%0t actual=timeout required=finish", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int rings, rsts;
        logic a, pz;
        logic [3:0] b [4];
        model_reset();
        #12;
        chk("reset_outputs", {cmd_start, cmd_pause, cmd_reset, cmd_load, set_mode, ring, seq_state}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 0);

        // Held start: one pulse only.
        apply(1, 1, 0, 0, 0, 0, 0);
        after_edge();
        chk("start_pulse", cmd_start, 1);
        chk("start_state", seq_state, 2);
        repeat (9) apply(1, 1, 0, 0, 0, 0, 0);
        after_edge();
        chk("no_second_start", cmd_start, 0);

        // Pause and clear together: clear wins.
        apply(1, 0, 0, 0, 0, 0, 0);
        apply(1, 0, 1, 1, 0, 0, 0);
        after_edge();
        chk("clear_beats_pause_reset", cmd_reset, 1);
        chk("clear_beats_pause_nopause", cmd_pause, 0);
        chk("clear_state", seq_state, 0);

        // Timer expiry and unacknowledged ring.
        apply(1, 0, 0, 0, 0, 0, 0);
        apply(1, 1, 0, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 0, 1);
        after_edge();
        chk("ring_state", seq_state, 4);
        rings = ring ? 1 : 0;
        rsts = 0;
        repeat (9) begin
            apply(1, 0, 0, 0, 0, 0, 0);
            after_edge();
            rings += ring ? 1 : 0;
            rsts += cmd_reset ? 1 : 0;
        end
        chk("ring_length", rings, RC);
        chk("ring_timeout_reset", rsts, 1);
        chk("ring_done_state", seq_state, 0);

        // SET entry and load; start ignored with zero preset.
        apply(1, 0, 0, 0, 2, 0, 0);
        after_edge();
        chk("set_mode", set_mode, 1);
        chk("set_state", seq_state, 1);
        apply(1, 0, 0, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 1, 0, 0);
        after_edge();
        chk("load_pulse", cmd_load, 1);
        chk("load_state", seq_state, 0);
        apply(1, 0, 0, 0, 0, 1, 0);
        apply(1, 1, 0, 0, 0, 1, 0);
        after_edge();
        chk("zero_preset_nostart", cmd_start, 0);
        chk("zero_preset_state", seq_state, 0);

        // Page deselect in PAUSE, then in RUN.
        apply(1, 0, 0, 0, 0, 0, 0);
        apply(1, 1, 0, 0, 0, 0, 0);
        apply(1, 1, 1, 0, 0, 0, 0);
        after_edge();
        chk("pause_state", seq_state, 3);
        apply(0, 0, 0, 0, 0, 0, 0);
        after_edge();
        chk("pause_drop_reset", cmd_reset, 1);
        chk("pause_drop_state", seq_state, 0);
        apply(1, 0, 0, 0, 0, 0, 0);
        apply(1, 1, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0, 0);
        after_edge();
`ifdef COUNTDOWN_BG_RUN_EN
        chk("run_drop_state", seq_state, 2);
        chk("run_drop_reset", cmd_reset, 0);
`else
        chk("run_drop_state", seq_state, 0);
        chk("run_drop_reset", cmd_reset, 1);
`endif
        apply(0, 0, 0, 0, 0, 0, 1);
        after_edge();
`ifdef COUNTDOWN_BG_RUN_EN
        chk("bg_ring", ring, 1);
`else
        chk("bg_ring", ring, 0);
`endif
        repeat (10) apply(0, 0, 0, 0, 0, 0, 0);

        // Async reset in the middle of a ring.
        apply(1, 0, 0, 0, 0, 0, 0);
        apply(1, 1, 0, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 0, 1);
        repeat (3) apply(1, 0, 0, 0, 0, 0, 0);
        after_edge();
        chk("ring_before_reset", ring, 1);
        reset_n = 1'b0;
        #1;
        chk("async_reset_ring", ring, 0);
        chk("async_reset_state", seq_state, 0);
        exp_q.delete();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 0);

        // Random traffic.
        a = 1'b1;
        pz = 1'b0;
        for (int i = 0; i < 4; i++) b[i] = 4'd0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 29) == 0) a = ~a;
            if ($urandom_range(0, 14) == 0) pz = ~pz;
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 3) == 0) b[i] = rand_code();
            apply(a, b[0], b[1], b[2], b[3], pz, ($urandom_range(0, 9) == 0));
        end
        after_edge();
        after_edge();
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
